// File: rtl/screen_pkg.sv
// Shared types and helpers for the screen serial transmitter.
//   uart_tx_state_t : frame sequencer states
//   IDLE_LEVEL      : level of the serial line between frames
//   calc_parity     : parity bit over a data word of up to 9 bits
package screen_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    localparam logic IDLE_LEVEL = 1'b1;

    // Narrower words are zero-extended by the caller; zeros do not change the XOR.
    // With odd=0 the returned bit makes the total count of ones even.
    function automatic logic calc_parity(input logic [8:0] word, input logic odd);
        return (^word) ^ odd;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO holding words waiting to be serialised.
//   clk, reset : clock and synchronous active-high reset (empties the queue)
//   push       : store wr_data (ignored while full)
//   pop        : discard the head word (ignored while empty)
//   rd_data    : head word, valid whenever empty is low
//   full/empty : occupancy flags derived from the registered count
//   count      : number of words held, registered
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             wr_en_s;
    logic             rd_en_s;

    assign full    = (count_r == CNT_W'(DEPTH));
    assign empty   = (count_r == {CNT_W{1'b0}});
    assign wr_en_s = push && !full;
    assign rd_en_s = pop && !empty;
    assign rd_data = mem_r[rd_ptr_r];
    assign count   = count_r;

    // Storage array; contents are only ever read when qualified by count.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/screen_uart_tx.sv
// Buffered serial transmitter driving the screen's serial input line.
// Words arrive over a valid/ready handshake, are queued, and are sent LSB first
// as: start bit (0), DATA_BITS data bits, optional parity bit, STOP_BITS stop bits (1).
//   clk        : system clock
//   reset      : synchronous active-high reset; aborts any frame and empties the queue
//   in_data    : word to send, captured when in_valid && in_ready
//   in_valid   : in_data is valid
//   in_ready   : queue can accept a word (registered, low during reset)
//   tx_out     : serial line, idles high (registered)
//   busy       : a frame is in flight or words are queued (registered)
//   fifo_count : number of queued words
module screen_uart_tx
    import screen_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic              ODD_SEL   = (PARITY_ODD != 0);

    uart_tx_state_t        state_r;
    uart_tx_state_t        state_next_s;
    logic [BAUD_W-1:0]     baud_r;
    logic [BAUD_W-1:0]     baud_next_s;
    logic [BIT_W-1:0]      bit_r;
    logic [BIT_W-1:0]      bit_next_s;
    logic [DATA_BITS-1:0]  shift_r;
    logic [DATA_BITS-1:0]  shift_next_s;
    logic                  parity_r;
    logic                  parity_next_s;
    logic                  tx_r;
    logic                  tx_next_s;
    logic                  busy_r;
    logic                  in_ready_r;

    logic                  push_s;
    logic                  pop_s;
    logic                  bit_end_s;
    logic [DATA_BITS-1:0]  fifo_head_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [CNT_W-1:0]      fifo_count_s;
    logic [CNT_W-1:0]      count_next_s;

    assign push_s     = in_valid && in_ready_r && !fifo_full_s;
    assign bit_end_s  = (baud_r == BAUD_LAST);
    assign in_ready   = in_ready_r;
    assign tx_out     = tx_r;
    assign busy       = busy_r;
    assign fifo_count = fifo_count_s;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_s),
        .pop     (pop_s),
        .wr_data (in_data),
        .rd_data (fifo_head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    // Frame sequencer: tx_next_s is the line level for the cycle after the edge,
    // so every transition loads the level of the bit being entered.
    always_comb begin
        state_next_s  = state_r;
        baud_next_s   = baud_r;
        bit_next_s    = bit_r;
        shift_next_s  = shift_r;
        parity_next_s = parity_r;
        tx_next_s     = tx_r;
        pop_s         = 1'b0;
        case (state_r)
            IDLE: begin
                baud_next_s = {BAUD_W{1'b0}};
                bit_next_s  = {BIT_W{1'b0}};
                if (!fifo_empty_s) begin
                    pop_s         = 1'b1;
                    shift_next_s  = fifo_head_s;
                    parity_next_s = calc_parity(9'(fifo_head_s), ODD_SEL);
                    state_next_s  = START;
                    tx_next_s     = 1'b0;
                end else begin
                    tx_next_s = IDLE_LEVEL;
                end
            end
            START: begin
                if (bit_end_s) begin
                    baud_next_s  = {BAUD_W{1'b0}};
                    bit_next_s   = {BIT_W{1'b0}};
                    state_next_s = DATA;
                    tx_next_s    = shift_r[0];
                end else begin
                    baud_next_s = baud_r + BAUD_W'(1);
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    baud_next_s = {BAUD_W{1'b0}};
                    if (bit_r == DATA_LAST) begin
                        bit_next_s = {BIT_W{1'b0}};
                        if (PARITY_EN != 0) begin
                            state_next_s = PARITY;
                            tx_next_s    = parity_r;
                        end else begin
                            state_next_s = STOP;
                            tx_next_s    = IDLE_LEVEL;
                        end
                    end else begin
                        // Bit 1 of the current shift value becomes the new LSB.
                        bit_next_s   = bit_r + BIT_W'(1);
                        shift_next_s = {1'b0, shift_r[DATA_BITS-1:1]};
                        tx_next_s    = shift_r[1];
                    end
                end else begin
                    baud_next_s = baud_r + BAUD_W'(1);
                end
            end
            PARITY: begin
                if (bit_end_s) begin
                    baud_next_s  = {BAUD_W{1'b0}};
                    bit_next_s   = {BIT_W{1'b0}};
                    state_next_s = STOP;
                    tx_next_s    = IDLE_LEVEL;
                end else begin
                    baud_next_s = baud_r + BAUD_W'(1);
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    baud_next_s = {BAUD_W{1'b0}};
                    if (bit_r == STOP_LAST) begin
                        bit_next_s = {BIT_W{1'b0}};
                        // Chain straight into the next frame when a word is waiting.
                        if (!fifo_empty_s) begin
                            pop_s         = 1'b1;
                            shift_next_s  = fifo_head_s;
                            parity_next_s = calc_parity(9'(fifo_head_s), ODD_SEL);
                            state_next_s  = START;
                            tx_next_s     = 1'b0;
                        end else begin
                            state_next_s = IDLE;
                            tx_next_s    = IDLE_LEVEL;
                        end
                    end else begin
                        bit_next_s = bit_r + BIT_W'(1);
                        tx_next_s  = IDLE_LEVEL;
                    end
                end else begin
                    baud_next_s = baud_r + BAUD_W'(1);
                end
            end
            default: begin
                state_next_s = IDLE;
                baud_next_s  = {BAUD_W{1'b0}};
                bit_next_s   = {BIT_W{1'b0}};
                tx_next_s    = IDLE_LEVEL;
            end
        endcase
    end

    // Queue occupancy after this edge, used to register busy and in_ready.
    always_comb begin
        count_next_s = fifo_count_s;
        case ({push_s, pop_s})
            2'b10:   count_next_s = fifo_count_s + CNT_W'(1);
            2'b01:   count_next_s = fifo_count_s - CNT_W'(1);
            default: count_next_s = fifo_count_s;
        endcase
    end

    // Sequencer state, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            baud_r     <= {BAUD_W{1'b0}};
            bit_r      <= {BIT_W{1'b0}};
            shift_r    <= {DATA_BITS{1'b0}};
            parity_r   <= 1'b0;
            tx_r       <= IDLE_LEVEL;
            busy_r     <= 1'b0;
            in_ready_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            baud_r     <= baud_next_s;
            bit_r      <= bit_next_s;
            shift_r    <= shift_next_s;
            parity_r   <= parity_next_s;
            tx_r       <= tx_next_s;
            busy_r     <= (state_next_s != IDLE) || (count_next_s != {CNT_W{1'b0}});
            in_ready_r <= (count_next_s != CNT_FULL);
        end
    end

endmodule

// File: tb/tb_screen_uart_tx.sv
`timescale 1ns/1ps
// Bench for screen_uart_tx: three configurations share clock and reset;
// sel chooses which one is driven and observed.
//   sel 0 : 8 data bits, 4 clk/bit, no parity, 1 stop
//   sel 1 : 8 data bits, 4 clk/bit, even parity, 1 stop
//   sel 2 : 7 data bits, 3 clk/bit, no parity, 2 stops
module tb_screen_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    int         sel;
    logic       valid;
    logic [7:0] data;
    logic       capture;

    logic       rdyA, txA, busyA, vA;
    logic       rdyB, txB, busyB, vB;
    logic       rdyC, txC, busyC, vC;
    logic [2:0] cntA, cntB, cntC;

    assign vA = valid && (sel == 0);
    assign vB = valid && (sel == 1);
    assign vC = valid && (sel == 2);

    logic       tx_m, busy_m, rdy_m;
    logic [2:0] cnt_m;
    assign tx_m   = (sel == 0) ? txA   : ((sel == 1) ? txB   : txC);
    assign busy_m = (sel == 0) ? busyA : ((sel == 1) ? busyB : busyC);
    assign rdy_m  = (sel == 0) ? rdyA  : ((sel == 1) ? rdyB  : rdyC);
    assign cnt_m  = (sel == 0) ? cntA  : ((sel == 1) ? cntB  : cntC);

    screen_uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4), .FIFO_DEPTH(4),
                     .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dutA (
        .clk(clk), .reset(reset), .in_data(data), .in_valid(vA), .in_ready(rdyA),
        .tx_out(txA), .busy(busyA), .fifo_count(cntA));

    screen_uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4), .FIFO_DEPTH(4),
                     .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dutB (
        .clk(clk), .reset(reset), .in_data(data), .in_valid(vB), .in_ready(rdyB),
        .tx_out(txB), .busy(busyB), .fifo_count(cntB));

    screen_uart_tx #(.DATA_BITS(7), .CLKS_PER_BIT(3), .FIFO_DEPTH(4),
                     .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dutC (
        .clk(clk), .reset(reset), .in_data(data[6:0]), .in_valid(vC), .in_ready(rdyC),
        .tx_out(txC), .busy(busyC), .fifo_count(cntC));

    int compared   = 0;
    int mismatched = 0;

    // Line monitor: one sample per cycle, away from the active edge.
    logic       txlog[$];
    logic       busylog[$];
    logic [2:0] maxcnt;
    logic       sawfull;
    always @(negedge clk) begin
        if (!capture) begin
            txlog.delete();
            busylog.delete();
            maxcnt  <= 3'd0;
            sawfull <= 1'b0;
        end else begin
            txlog.push_back(tx_m);
            busylog.push_back(busy_m);
            if (cnt_m > maxcnt) maxcnt <= cnt_m;
            if (!rdy_m) sawfull <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0] wq[$];
    logic [2:0] last_maxcnt;
    logic       last_sawfull;

    // Pushes every word in wq as fast as in_ready allows and checks the line
    // and busy cycle by cycle against frames built from the framing rules.
    task automatic run_stream(input string tag);
        int   nb   = (sel == 2) ? 7 : 8;
        int   cpb  = (sel == 2) ? 3 : 4;
        int   stp  = (sel == 2) ? 2 : 1;
        bit   par  = (sel == 1);
        logic exp_tx[$];
        logic exp_busy[$];
        logic fb[$];
        int   fc, guard, idx, ones;

        // Line stays idle for the push edge and the pop edge, then frames follow back to back.
        exp_tx.push_back(1'b1);
        exp_tx.push_back(1'b1);
        foreach (wq[w]) begin
            fb.delete();
            fb.push_back(1'b0);
            ones = 0;
            for (int i = 0; i < nb; i++) begin
                fb.push_back(wq[w][i]);
                ones += int'(wq[w][i]);
            end
            if (par) fb.push_back((ones % 2) == 1);
            repeat (stp) fb.push_back(1'b1);
            foreach (fb[b]) repeat (cpb) exp_tx.push_back(fb[b]);
        end
        fc = exp_tx.size() - 2;
        repeat (6) exp_tx.push_back(1'b1);
        exp_busy.push_back(1'b0);
        repeat (1 + fc) exp_busy.push_back(1'b1);
        repeat (6) exp_busy.push_back(1'b0);

        @(posedge clk); #1;
        capture = 1'b1;
        idx = 0;
        guard = 0;
        while (idx < wq.size() && guard < 2000) begin
            if (rdy_m) begin
                valid = 1'b1;
                data  = wq[idx];
                idx++;
            end else begin
                valid = 1'b0;
                data  = 8'($urandom);
            end
            @(posedge clk); #1;
            guard++;
        end
        valid = 1'b0;
        data  = 8'($urandom);
        check({tag, "_pushed"}, idx, wq.size());

        guard = 0;
        while (txlog.size() < exp_tx.size() && guard < 5000) begin
            @(posedge clk);
            guard++;
        end
        check({tag, "_captured"}, 32'(txlog.size() >= exp_tx.size()), 32'd1);
        if (txlog.size() >= exp_tx.size()) begin
            for (int i = 0; i < exp_tx.size(); i++) begin
                check($sformatf("%s_tx[%0d]", tag, i), 32'(txlog[i]), 32'(exp_tx[i]));
                check($sformatf("%s_busy[%0d]", tag, i), 32'(busylog[i]), 32'(exp_busy[i]));
            end
        end
        last_maxcnt  = maxcnt;
        last_sawfull = sawfull;
        capture = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w0, w1, w2;
        int n;
        reset   = 1'b1;
        valid   = 1'b0;
        data    = 8'h00;
        sel     = 0;
        capture = 1'b0;

        // Reset held three cycles, then released.
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            check($sformatf("rst_tx_s%0d", s), 32'(tx_m), 32'd1);
            check($sformatf("rst_busy_s%0d", s), 32'(busy_m), 32'd0);
            check($sformatf("rst_cnt_s%0d", s), 32'(cnt_m), 32'd0);
            check($sformatf("rst_rdy_s%0d", s), 32'(rdy_m), 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            check($sformatf("rdy_not_yet_s%0d", s), 32'(rdy_m), 32'd0);
        end
        @(posedge clk); #1;
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            check($sformatf("rdy_rise_s%0d", s), 32'(rdy_m), 32'd1);
            check($sformatf("idle_tx_s%0d", s), 32'(tx_m), 32'd1);
            check($sformatf("idle_busy_s%0d", s), 32'(busy_m), 32'd0);
        end

        // Single 8'hA2 frame, no parity.
        sel = 0;
        wq = '{8'hA2};
        run_stream("t2_a2");

        // Even parity, two words chained.
        sel = 1;
        wq = '{8'hA2, 8'h7B};
        run_stream("t3_par");

        // Six back-to-back words fill the four-deep queue.
        sel = 0;
        wq.delete();
        repeat (6) wq.push_back(8'($urandom));
        run_stream("t4_six");
        check("t4_maxcnt", 32'(last_maxcnt), 32'd4);
        check("t4_ready_dropped", 32'(last_sawfull), 32'd1);

        // 7 data bits, 2 stop bits, 3 clocks per bit.
        sel = 2;
        wq = '{8'h55};
        run_stream("t6_7b2s");

        // Random batches on every configuration.
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < 3; k++) begin
                sel = s;
                wq.delete();
                n = $urandom_range(1, 4);
                repeat (n) wq.push_back(8'($urandom));
                run_stream($sformatf("rnd_s%0d_%0d", s, k));
            end
        end

        // Reset in the middle of a frame with words still queued.
        sel = 0;
        w0 = 8'($urandom);
        w1 = 8'($urandom);
        w2 = 8'($urandom);
        @(posedge clk); #1;
        valid = 1'b1; data = w0;
        @(posedge clk); #1;
        data = w1;
        @(posedge clk); #1;
        data = w2;
        @(posedge clk); #1;
        valid = 1'b0;
        check("t5_cnt_before", 32'(cnt_m), 32'd2);
        check("t5_busy_before", 32'(busy_m), 32'd1);
        check("t5_start_bit", 32'(tx_m), 32'd0);
        repeat (14) @(posedge clk);
        #1;
        // Sixteenth cycle of the frame: last cycle of data bit 2.
        check("t5_data_bit2", 32'(tx_m), 32'(w0[2]));
        reset = 1'b1;
        @(posedge clk); #1;
        check("t5_tx_after_rst", 32'(tx_m), 32'd1);
        check("t5_cnt_after_rst", 32'(cnt_m), 32'd0);
        check("t5_busy_after_rst", 32'(busy_m), 32'd0);
        check("t5_rdy_after_rst", 32'(rdy_m), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            check($sformatf("t5_quiet_tx[%0d]", i), 32'(tx_m), 32'd1);
            check($sformatf("t5_quiet_busy[%0d]", i), 32'(busy_m), 32'd0);
        end
        check("t5_rdy_back", 32'(rdy_m), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
